// File: rtl/gelato_simd_alu.sv
// Multi-lane SIMD ALU: one masked warp-slice op per request handshake, tagged response.
// Single-cycle ops complete on accept; MUL runs through a counted BUSY phase.
module gelato_simd_alu #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_op,
    input  logic [LANES-1:0]        req_mask,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic [LANES*XLEN-1:0]   req_rs1,
    input  logic [LANES*XLEN-1:0]   req_rs2,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LANES*XLEN-1:0]   resp_rd,
    output logic [LANES-1:0]        resp_mask,
    output logic [TAG_W-1:0]        resp_tag,
    output logic                    resp_err
);

    localparam int unsigned DW    = LANES * XLEN;
    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DW-1:0]    mul_a, mul_a_n;
    logic [DW-1:0]    mul_b, mul_b_n;
    logic             valid_n;
    logic [DW-1:0]    rd_n;
    logic [LANES-1:0] mask_n;
    logic [TAG_W-1:0] tag_n;
    logic             err_n;

    logic             accept;
    logic             illegal;
    logic [DW-1:0]    alu_rd;
    logic [DW-1:0]    mul_rd;

    // Single-cycle lane operation; illegal and MUL opcodes yield zero here.
    function automatic logic [XLEN-1:0] lane_alu(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        r  = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = XLEN'($signed(a) >>> sh);
            OP_SLT:  r = XLEN'($signed(a) < $signed(b));
            OP_SLTU: r = XLEN'(a < b);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign req_ready = rdy && ((state == S_IDLE) || ((state == S_DONE) && resp_ready));
    assign accept    = req_valid && req_ready;
    assign illegal   = (req_op > OP_MUL);

    always_comb begin
        alu_rd = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (req_mask[i]) begin
                alu_rd[i*XLEN +: XLEN] = lane_alu(req_op, req_rs1[i*XLEN +: XLEN],
                                                  req_rs2[i*XLEN +: XLEN]);
            end
        end
    end

    // Products come from the latched operands; mask was captured at accept.
    always_comb begin
        mul_rd = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (resp_mask[i]) begin
                mul_rd[i*XLEN +: XLEN] = mul_a[i*XLEN +: XLEN] * mul_b[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mul_a_n = mul_a;
        mul_b_n = mul_b;
        valid_n = resp_valid;
        rd_n    = resp_rd;
        mask_n  = resp_mask;
        tag_n   = resp_tag;
        err_n   = resp_err;
        if (rdy) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        mask_n = req_mask;
                        tag_n  = req_tag;
                        if (req_op == OP_MUL) begin
                            mul_a_n = req_rs1;
                            mul_b_n = req_rs2;
                            cnt_n   = CNT_W'(MUL_LAT - 1);
                            err_n   = 1'b0;
                            valid_n = 1'b0;
                            state_n = S_BUSY;
                        end else begin
                            rd_n    = alu_rd;
                            err_n   = illegal;
                            valid_n = 1'b1;
                            state_n = S_DONE;
                        end
                    end else if ((state == S_DONE) && resp_ready) begin
                        valid_n = 1'b0;
                        state_n = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        rd_n    = mul_rd;
                        valid_n = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_valid <= 1'b0;
            resp_rd    <= '0;
            resp_mask  <= '0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mul_a      <= mul_a_n;
            mul_b      <= mul_b_n;
            resp_valid <= valid_n;
            resp_rd    <= rd_n;
            resp_mask  <= mask_n;
            resp_tag   <= tag_n;
            resp_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_gelato_simd_alu.sv
// Self-checking bench for gelato_simd_alu: directed vectors plus randomized ops
// compared against a plain-arithmetic lane model.
module tb_gelato_simd_alu;

    localparam int unsigned LANES   = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DW      = LANES * XLEN;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [LANES-1:0] req_mask;
    logic [TAG_W-1:0] req_tag;
    logic [DW-1:0]    req_rs1;
    logic [DW-1:0]    req_rs2;
    logic             resp_valid;
    logic             resp_ready;
    logic [DW-1:0]    resp_rd;
    logic [LANES-1:0] resp_mask;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    int checks = 0;
    int errors = 0;

    gelato_simd_alu #(.LANES(LANES), .XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_mask(req_mask), .req_tag(req_tag), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_mask(resp_mask), .resp_tag(resp_tag), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference: each lane computed from the opcode's arithmetic definition.
    function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [LANES-1:0] m,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]     r;
        logic [XLEN-1:0]   x, y, z;
        logic [2*XLEN-1:0] p;
        longint            sx, sy;
        int                sh;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            x  = a[i*XLEN +: XLEN];
            y  = b[i*XLEN +: XLEN];
            sh = int'(y % XLEN);
            sx = x[XLEN-1] ? longint'(x) - (longint'(1) <<< XLEN) : longint'(x);
            sy = y[XLEN-1] ? longint'(y) - (longint'(1) <<< XLEN) : longint'(y);
            case (op)
                4'd0:    z = x + y;
                4'd1:    z = x - y;
                4'd2:    z = x & y;
                4'd3:    z = x | y;
                4'd4:    z = x ^ y;
                4'd5:    z = x << sh;
                4'd6:    z = x >> sh;
                4'd7:    z = x[XLEN-1] ? ~((~x) >> sh) : (x >> sh);
                4'd8:    z = (sx < sy) ? XLEN'(1) : XLEN'(0);
                4'd9:    z = (x < y) ? XLEN'(1) : XLEN'(0);
                4'd10: begin
                    p = (2*XLEN)'(x) * (2*XLEN)'(y);
                    z = p[XLEN-1:0];
                end
                default: z = '0;
            endcase
            if (m[i]) r[i*XLEN +: XLEN] = z;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < int'(LANES); i++) v[i*XLEN +: XLEN] = XLEN'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after the edge that accepted it.
    task automatic issue(input logic [3:0] op, input logic [LANES-1:0] m,
                         input logic [TAG_W-1:0] t, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        int n;
        req_op    = op;
        req_mask  = m;
        req_tag   = t;
        req_rs1   = a;
        req_rs2   = b;
        req_valid = 1'b1;
        n = 0;
        #1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL issue_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        req_op = '0; req_mask = '0; req_tag = '0; req_rs1 = '0; req_rs2 = '0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rd !== '0 || resp_mask !== '0 ||
            resp_tag !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b rd=%h mask=%b tag=%h err=%b, required all 0",
                     resp_valid, resp_rd, resp_mask, resp_tag, resp_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_single_ops();
        logic [DW-1:0]    a, b, e;
        logic [3:0]       op;
        logic [LANES-1:0] m;
        logic [TAG_W-1:0] t;
        // ADD with wrap-around and a masked lane
        a = {32'd7, 32'd5, 32'hFFFF_FFFF, 32'd1};
        b = {32'd9, 32'd3, 32'd1, 32'd2};
        issue(4'd0, 4'b1011, 6'h05, a, b);
        checks++;
        if (resp_valid !== 1'b1 || resp_rd !== {32'd16, 32'd0, 32'd0, 32'd3} || resp_mask !== 4'b1011) begin
            errors++;
            $display("FAIL add_directed: valid=%b rd=%h mask=%b, required 1 %h 1011",
                     resp_valid, resp_rd, resp_mask, {32'd16, 32'd0, 32'd0, 32'd3});
        end
        a = {4{32'h8000_0000}};
        b = {4{32'd36}};
        issue(4'd7, 4'hF, 6'h06, a, b);
        checks++;
        if (resp_rd !== {4{32'hF800_0000}}) begin
            errors++;
            $display("FAIL sra_directed: got %h required %h", resp_rd, {4{32'hF800_0000}});
        end
        a = {4{32'hFFFF_FFFF}};
        b = {4{32'd1}};
        issue(4'd8, 4'hF, 6'h07, a, b);
        checks++;
        if (resp_rd !== {4{32'd1}}) begin
            errors++;
            $display("FAIL slt_directed: got %h required %h", resp_rd, {4{32'd1}});
        end
        issue(4'd9, 4'hF, 6'h08, a, b);
        checks++;
        if (resp_rd !== '0) begin
            errors++;
            $display("FAIL sltu_directed: got %h required 0", resp_rd);
        end
        for (int k = 0; k < 40; k++) begin
            op = (k < 4) ? 4'd1 : 4'($urandom_range(0, 9));
            m  = LANES'($urandom);
            t  = TAG_W'($urandom);
            a  = rand_vec();
            b  = rand_vec();
            if (k % 5 == 0) b[XLEN-1:0] = XLEN'($urandom_range(0, 70));
            e  = model(op, m, a, b);
            issue(op, m, t, a, b);
            checks++;
            if (resp_valid !== 1'b1 || resp_rd !== e || resp_mask !== m ||
                resp_tag !== t || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL rand_op%0d: valid=%b rd=%h mask=%b tag=%h err=%b, required 1 %h %b %h 0",
                         op, resp_valid, resp_rd, resp_mask, resp_tag, resp_err, e, m, t);
            end
        end
        tick();
    endtask

    task automatic test_mul();
        logic [DW-1:0]    a, b, e;
        logic [LANES-1:0] m;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                a = {4{32'h0001_0000}};
                b = {4{32'h0001_0001}};
                m = 4'hF;
                e = {4{32'h0001_0000}};
            end else begin
                a = rand_vec();
                b = rand_vec();
                m = LANES'($urandom);
                e = model(4'd10, m, a, b);
            end
            issue(4'd10, m, TAG_W'(k + 16), a, b);
            for (int j = 0; j < int'(MUL_LAT) - 1; j++) begin
                checks++;
                if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_busy: cycle %0d valid=%b req_ready=%b, required 0 0",
                             j, resp_valid, req_ready);
                end
                tick();
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_rd !== e || resp_tag !== TAG_W'(k + 16) || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL mul_result%0d: valid=%b rd=%h tag=%h, required 1 %h %h",
                         k, resp_valid, resp_rd, resp_tag, e, TAG_W'(k + 16));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]    a, b, e;
        logic [DW-1:0]    exp_q[$];
        a = rand_vec();
        b = rand_vec();
        e = model(4'd0, 4'hF, a, b);
        resp_ready = 1'b0;
        issue(4'd0, 4'hF, 6'h11, a, b);
        req_valid = 1'b1;
        req_rs1   = rand_vec();
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rd !== e || resp_tag !== 6'h11 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: cycle %0d valid=%b rd=%h tag=%h req_ready=%b, required 1 %h 11 0",
                         j, resp_valid, resp_rd, resp_tag, req_ready, e);
            end
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            req_op    = 4'd0;
            req_mask  = LANES'($urandom);
            req_tag   = TAG_W'(k);
            req_rs1   = rand_vec();
            req_rs2   = rand_vec();
            req_valid = 1'b1;
            exp_q.push_back(model(4'd0, req_mask, req_rs1, req_rs2));
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: beat %0d got %b required 1", k, req_ready);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (resp_valid !== 1'b1 || resp_tag !== TAG_W'(k) || resp_rd !== e) begin
                errors++;
                $display("FAIL stream_resp: beat %0d valid=%b tag=%h rd=%h, required 1 %h %h",
                         k, resp_valid, resp_tag, resp_rd, TAG_W'(k), e);
            end
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b required 0", resp_valid);
        end
    endtask

    task automatic test_illegal();
        logic [DW-1:0] a, b, e;
        issue(4'd13, 4'hF, 6'h2A, rand_vec(), rand_vec());
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rd !== '0 || resp_tag !== 6'h2A) begin
            errors++;
            $display("FAIL illegal_op: valid=%b err=%b rd=%h tag=%h, required 1 1 0 2a",
                     resp_valid, resp_err, resp_rd, resp_tag);
        end
        a = rand_vec();
        b = rand_vec();
        e = model(4'd4, 4'hF, a, b);
        issue(4'd4, 4'hF, 6'h2B, a, b);
        checks++;
        if (resp_err !== 1'b0 || resp_rd !== e) begin
            errors++;
            $display("FAIL after_illegal: err=%b rd=%h, required 0 %h", resp_err, resp_rd, e);
        end
        tick();
    endtask

    task automatic test_stall_reset();
        logic [DW-1:0] a, b, e;
        a = rand_vec();
        b = rand_vec();
        e = model(4'd10, 4'hF, a, b);
        issue(4'd10, 4'hF, 6'h33, a, b);
        tick();
        rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_busy: cycle %0d valid=%b req_ready=%b, required 0 0",
                         j, resp_valid, req_ready);
            end
        end
        rdy = 1'b1;
        for (int j = 0; j < int'(MUL_LAT) - 3; j++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_early: valid=%b required 0", resp_valid);
            end
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_rd !== e || resp_tag !== 6'h33) begin
            errors++;
            $display("FAIL stall_mul: valid=%b rd=%h tag=%h, required 1 %h 33",
                     resp_valid, resp_rd, resp_tag, e);
        end
        // Frozen in DONE: response survives even with resp_ready high.
        rdy = 1'b0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_rd !== e) begin
            errors++;
            $display("FAIL stall_done: valid=%b rd=%h, required 1 %h", resp_valid, resp_rd, e);
        end
        rdy = 1'b1;
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b required 0", resp_valid);
        end
        // Reset during DONE, with rdy low: reset must still win.
        resp_ready = 1'b0;
        issue(4'd3, 4'hF, 6'h3C, rand_vec() | {DW{1'b0}} | {{(DW-1){1'b0}}, 1'b1}, rand_vec());
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid=%b required 1", resp_valid);
        end
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rd !== '0 || resp_tag !== '0 || resp_mask !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: valid=%b rd=%h tag=%h mask=%b err=%b, required all 0",
                     resp_valid, resp_rd, resp_tag, resp_mask, resp_err);
        end
        rst = 1'b0;
        rdy = 1'b1;
        resp_ready = 1'b1;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/gelato_simd_alu.md
# gelato_simd_alu

Parametrised multi-lane ALU for the Gelato compute core: accepts one warp-slice operation per handshake, computes it across `LANES` lanes of `XLEN` bits under a per-lane active mask and returns a tagged result. It replaces the single-op, single-lane ALU. It adds a wider op set, a multi-cycle multiply, valid/ready flow control on both sides and error reporting instead of simulation-fatal checks. It sits between the issue stage (request side) and the writeback arbiter (response side).

## Interface
- `LANES`, 4: number of parallel lanes (≥1).
- `XLEN`, 32: lane data width (power of two, ≥8).
- `TAG_W`, 6: width of the opaque request tag returned with the result.
- `MUL_LAT`, 3: cycles from accept to response for MUL (≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `rdy`  in  1  global enable; when low, all state and outputs are frozen and `req_ready`=0.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on a cycle where `req_valid && req_ready`.
- `req_op`  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11–15 are illegal.
- `req_mask`  in  LANES  per-lane active mask.
- `req_tag`  in  TAG_W  tag.
- `req_rs1`, `req_rs2`  in  LANES*XLEN  operands; lane i occupies bits [i*XLEN +: XLEN].
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_rd`  out  LANES*XLEN  result.
- `resp_mask`, `resp_tag`  out  LANES / TAG_W  echoed from the request.
- `resp_err`  out  1  illegal opcode.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE, on accept:
  - Non-MUL ops: compute and register the result, then go to DONE.
  - MUL: latch the operands, load the counter with `MUL_LAT-1`, then go to BUSY.
- BUSY: decrement the counter each enabled cycle. At 1, register the products and go to DONE.
- DONE: `resp_valid`=1.
  - On `resp_ready` with no new accept: go to IDLE.
  - On a same-cycle accept: handle it exactly as IDLE does (back-to-back).
- `req_ready` = `rdy && (state==IDLE || (state==DONE && resp_ready))`. This is combinational and never depends on `req_valid`.
- Arithmetic rules:
  - All arithmetic is modulo 2^XLEN.
  - The shift amount is `rs2[$clog2(XLEN)-1:0]`. SRA is arithmetic.
  - SLT and SLTU return 1 or 0, zero-extended; SLT compares signed, SLTU unsigned.
  - MUL returns the low XLEN bits; signedness is irrelevant.
- Masked lanes (mask bit 0) have `resp_rd` lane = 0.
- Illegal opcode: takes the single-cycle path; `resp_err`=1 and all `resp_rd`=0. No simulation fatal is raised.
- `resp_*` payload stays stable while `resp_valid && !resp_ready`.
- `rdy` low: the FSM, counter and outputs all hold, including in BUSY. Response handshakes cannot complete, because the whole block is frozen.

## Timing
- Reset values: `resp_valid`=0, `resp_rd`=0, `resp_mask`=0, `resp_tag`=0, `resp_err`=0, state=IDLE. `req_ready`=`rdy` while in IDLE after reset.
- Latency: single-cycle op accepted at edge N gives `resp_valid` after edge N+1. MUL accepted at edge N gives `resp_valid` after edge N+`MUL_LAT`.
- Throughput: 1 op/cycle for single-cycle ops when `resp_ready` is held high. MUL allows one op per `MUL_LAT` cycles.
- `rst` asserted mid-BUSY or mid-DONE: the in-flight result is discarded and the next cycle is IDLE with all outputs at reset values.
- `rst` and `rdy` together: reset wins.
- Result registers update only on a state-advancing enabled edge.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles -> `resp_valid`=0 and all outputs 0; `req_ready`=1 with `rdy`=1.
- **Single-cycle ops:** LANES=4, ADD with rs1 lanes {1, 0xFFFFFFFF, 5, 7}, rs2 {2, 1, 3, 9}, mask 4'b1011 -> one cycle later rd {3, 0, 0, 16}.
  - Lane 1 is 0 from wrap-around; lane 2 is 0 because it is masked.
  - Repeat for SUB, SRA with rs1=0x80000000 and rs2=36 (shift 4) -> 0xF8000000, and SLT of -1 vs 1 -> 1 versus SLTU of the same operands -> 0.
- **MUL latency:** MUL 0x10000 × 0x10001 -> rd 0x00010000 exactly `MUL_LAT` cycles after accept; `req_ready`=0 throughout BUSY.
- **Backpressure/back-to-back:**
  - Hold `resp_ready`=0 for 5 cycles -> payload stable and `req_ready`=0.
  - Then stream 8 ADDs with `resp_ready`=1 -> 8 responses on consecutive cycles, tags in order.
- **Illegal op:** `req_op`=13, tag 0x2A -> `resp_err`=1, rd all 0, tag 0x2A; the next legal op has `resp_err`=0.
- **Stall and reset:**
  - Drop `rdy` for 3 cycles mid-BUSY -> the MUL response is delayed by exactly 3 cycles.
  - Assert `rst` during DONE -> `resp_valid`=0 on the next cycle and the result is lost.
